// File: rtl/io_write_arbiter.sv
// Round-robin arbiter that shares the output-port register block's single write port
// between two requesters. Each requester has a one-entry buffer and a valid/ready handshake.
module io_write_arbiter #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              io_clk,
   input  logic              resetn,
   input  logic              req0_valid,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   output logic              req0_ready,
   input  logic              req1_valid,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   output logic              req1_ready,
   output logic              write_io_enable,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] datain,
   output logic              grant_id,
   output logic              err_addr,
   output logic [CNT_W-1:0]  wr_count0,
   output logic [CNT_W-1:0]  wr_count1
);

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_0    = 2'd1,
      SEL_1    = 2'd2
   } sel_e;

   logic              buf0_full;
   logic              buf1_full;
   logic [ADDR_W-1:0] buf0_addr;
   logic [ADDR_W-1:0] buf1_addr;
   logic [DATA_W-1:0] buf0_data;
   logic [DATA_W-1:0] buf1_data;
   logic              last_grant;

   sel_e              sel;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              sel_mapped;

   // Ready comes straight from buffer state, so a freed buffer is visible only after the edge.
   assign req0_ready = ~buf0_full;
   assign req1_ready = ~buf1_full;

   always_comb begin
      sel = SEL_NONE;
      if (buf0_full && buf1_full) begin
         sel = last_grant ? SEL_0 : SEL_1;
      end else if (buf0_full) begin
         sel = SEL_0;
      end else if (buf1_full) begin
         sel = SEL_1;
      end
   end

   always_comb begin
      sel_addr   = (sel == SEL_1) ? buf1_addr : buf0_addr;
      sel_data   = (sel == SEL_1) ? buf1_data : buf0_data;
      sel_mapped = (sel_addr[7:2] >= 6'h20) && (sel_addr[7:2] <= 6'h22);
   end

   // A buffer cannot be accepted into and granted in the same edge: accept needs it empty.
   always_ff @(posedge io_clk or negedge resetn) begin
      if (!resetn) begin
         buf0_full <= 1'b0;
         buf0_addr <= '0;
         buf0_data <= '0;
      end else if (req0_valid && !buf0_full) begin
         buf0_full <= 1'b1;
         buf0_addr <= req0_addr;
         buf0_data <= req0_data;
      end else if (sel == SEL_0) begin
         buf0_full <= 1'b0;
      end
   end

   always_ff @(posedge io_clk or negedge resetn) begin
      if (!resetn) begin
         buf1_full <= 1'b0;
         buf1_addr <= '0;
         buf1_data <= '0;
      end else if (req1_valid && !buf1_full) begin
         buf1_full <= 1'b1;
         buf1_addr <= req1_addr;
         buf1_data <= req1_data;
      end else if (sel == SEL_1) begin
         buf1_full <= 1'b0;
      end
   end

   always_ff @(posedge io_clk or negedge resetn) begin
      if (!resetn) begin
         write_io_enable <= 1'b0;
         err_addr        <= 1'b0;
         addr            <= '0;
         datain          <= '0;
         grant_id        <= 1'b0;
         last_grant      <= 1'b1;
         wr_count0       <= '0;
         wr_count1       <= '0;
      end else begin
         write_io_enable <= 1'b0;
         err_addr        <= 1'b0;
         if (sel != SEL_NONE) begin
            addr       <= sel_addr;
            datain     <= sel_data;
            grant_id   <= (sel == SEL_1);
            last_grant <= (sel == SEL_1);
            if (sel_mapped) begin
               write_io_enable <= 1'b1;
               if (sel == SEL_1) begin
                  if (wr_count1 != '1) wr_count1 <= wr_count1 + 1'b1;
               end else begin
                  if (wr_count0 != '1) wr_count0 <= wr_count0 + 1'b1;
               end
            end else begin
               err_addr <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/io_write_arbiter.md
Name: io_write_arbiter

Overview:
Shares the single write port of the memory-mapped output-port register block between two requesters: requester 0 (CPU pipeline store path) and requester 1 (auxiliary master, e.g. a display/refresh sequencer). Each requester has a one-entry request buffer with a valid/ready handshake. A round-robin arbiter drains one buffered write per cycle onto the registered write_io_enable/addr/datain bus. Writes to addresses outside the output-port map are consumed and flagged, never issued.

Parameters:
DATA_W, 32, width of write data and datain bus
ADDR_W, 32, width of request and output address
CNT_W, 16, width of per-requester saturating issued-write counters

Ports:
io_clk  in  1  clock; all state changes on rising edge
resetn  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has a write
req0_addr  in  ADDR_W  requester 0 byte address
req0_data  in  DATA_W  requester 0 write data
req0_ready  out  1  requester 0 buffer empty; accept when valid&&ready
req1_valid  in  1  requester 1 has a write
req1_addr  in  ADDR_W  requester 1 byte address
req1_data  in  DATA_W  requester 1 write data
req1_ready  out  1  requester 1 buffer empty
write_io_enable  out  1  registered one-cycle write strobe to output-port block
addr  out  ADDR_W  registered write address
datain  out  DATA_W  registered write data
grant_id  out  1  requester owning the current slot (valid when write_io_enable or err_addr)
err_addr  out  1  one-cycle pulse: slot consumed an unmapped address
wr_count0  out  CNT_W  writes issued for requester 0, saturating
wr_count1  out  CNT_W  writes issued for requester 1, saturating

Behaviour:
- Reset (resetn=0, async): both buffers empty, req0_ready=req1_ready=1, write_io_enable=0, addr=0, datain=0, grant_id=0, err_addr=0, wr_count0=wr_count1=0, last_grant=1 (requester 0 wins first tie). Any buffered or in-flight write is dropped. No write strobe is issued during reset or in the first cycle after release.
- Accept: at a rising edge with reqN_valid&&reqN_ready, capture addr/data into buffer N and set it full. reqN_ready = ~bufN_full, driven from a register with no combinational path from valid.
- No bypass: a buffer freed at edge k shows ready=1 only after edge k. Max per-requester rate is one write every 2 cycles. Aggregate rate is one slot per cycle when both requesters are active.
- Arbitration, evaluated each cycle on buffer state:
  - Neither buffer full: idle. write_io_enable=0 and err_addr=0 at the next edge.
  - Exactly one full: grant it.
  - Both full: grant the requester != last_grant.
  - The granted buffer empties at the edge, and last_grant and grant_id are set to the granted requester.
- Issue: at the grant edge, register addr<=buf.addr and datain<=buf.data.
  - If buf.addr[7:2] is 6'h20, 6'h21 or 6'h22: write_io_enable<=1 and increment that requester's counter, which holds at all-ones.
  - Otherwise: write_io_enable<=0, err_addr<=1, counter unchanged.
  - Strobes are single-cycle; outputs return to 0 at the next edge unless another grant occurs.
- Latency: accept at edge k, grant at edge k+1 at earliest, output block samples at edge k+2. Worst case when contending is +1 cycle.
- Ordering: writes from one requester issue in acceptance order (one-entry buffer). No ordering is guaranteed between requesters.
- addr and datain hold their last values while idle. Only write_io_enable qualifies them.
- Simultaneous accept into the just-freed other buffer and grant in the same edge is legal and independent.
- Reset asserted mid-operation: all state returns to reset values immediately. No strobe completes afterward.

Test Plan:
- Reset then single write: req0 addr=0x80, data=0xDEADBEEF, held one cycle. Required: write_io_enable=1 exactly one cycle, 2 edges after accept; addr=0x80; datain=0xDEADBEEF; grant_id=0; wr_count0=1.
- Tie after reset: both requesters valid at the same edge (req0 0x84/0x11, req1 0x88/0x22). Required: req0 issues first, req1 next cycle; back-to-back strobes; grant_id 0 then 1.
- Sustained contention: both valid continuously for 10 writes each. Required: strict alternation 0,1,0,1…; no starvation; wr_count0=wr_count1=10; reqN_ready toggles every other cycle.
- Unmapped address: req1 addr=0x8C. Required: err_addr pulses 1 cycle with grant_id=1; write_io_enable stays 0; wr_count1 unchanged; buffer freed.
- Reset mid-flight: assert resetn=0 while both buffers are full. Required: ready=1, no strobe before or after release; counters=0; next request behaves as in the first scenario.
- Saturation: force 2^CNT_W+3 valid writes on req0 (CNT_W=4 in bench). Required: wr_count0 stops at 15.
